// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_WIDTH    = 32;
    localparam logic [31:0] FETCH_NOP      = 32'hFC00_0000;
    localparam int unsigned PC_STEP        = 4;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef logic [FETCH_WIDTH-1:0] pc_t;

endpackage : fetch_pkg

// File: rtl/fetch_hold_buffer.sv
// Captures the ROM output on the first stalled edge so the instruction
// stays paired with its PC while the ROM moves on to the next address.
module fetch_hold_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(FETCH_NOP)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             capture_i,
    input  logic             release_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic             held_q, held_d;
    logic [WIDTH-1:0] hold_instr_q, hold_instr_d;

    // Next-state: release wins; capture only once per stall episode.
    always_comb begin
        held_d       = held_q;
        hold_instr_d = hold_instr_q;
        if (release_i) begin
            held_d = 1'b0;
        end else if (capture_i && !held_q) begin
            held_d       = 1'b1;
            hold_instr_d = din_i;
        end
    end

    // Hold-buffer state registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            held_q       <= 1'b0;
            hold_instr_q <= RESET_VAL;
        end else begin
            held_q       <= held_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign dout_o = held_q ? hold_instr_q : din_i;

endmodule : fetch_hold_buffer

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and pairs the
// registered ROM output with its PC. Handles stall and branch redirect.
// Optional feature: FETCH_MISALIGN_CHECK_EN aligns redirect targets and
// raises a sticky MISALIGN_ERR on a misaligned redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(FETCH_RESET_PC),
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(FETCH_NOP)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             STALL,
    input  logic             BRANCH_TAKEN,
    input  logic [WIDTH-1:0] BRANCH_TARGET,
    output logic [WIDTH-1:0] ROM_ADDRESS,
    input  logic [WIDTH-1:0] ROM_INSTR,
    output logic [WIDTH-1:0] IF_INSTR,
    output logic [WIDTH-1:0] IF_PC,
    output logic [WIDTH-1:0] IF_PC_PLUS4,
    output logic             IF_VALID,
    output logic             MISALIGN_ERR
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] f2_pc_q, f2_pc_d;
    logic             f2_valid_q, f2_valid_d;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] buf_instr;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign target = {BRANCH_TARGET[WIDTH-1:2], 2'b00};

    // Sticky flag: any misaligned redirect sets it until reset.
    always_comb begin
        misalign_d = misalign_q | (BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00));
    end

    // Misalignment flag register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign MISALIGN_ERR = misalign_q;
`else
    assign target       = BRANCH_TARGET;
    assign MISALIGN_ERR = 1'b0;
`endif

    // Priority: redirect beats stall beats normal advance.
    always_comb begin
        pc_d       = pc_q;
        f2_pc_d    = f2_pc_q;
        f2_valid_d = f2_valid_q;
        if (BRANCH_TAKEN) begin
            pc_d       = target;
            f2_valid_d = 1'b0;
        end else if (!STALL) begin
            pc_d       = pc_q + WIDTH'(PC_STEP);
            f2_pc_d    = pc_q;
            f2_valid_d = 1'b1;
        end
    end

    // PC and fetch-2 pipeline registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q       <= RESET_PC;
            f2_pc_q    <= '0;
            f2_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            f2_pc_q    <= f2_pc_d;
            f2_valid_q <= f2_valid_d;
        end
    end

    fetch_hold_buffer #(
        .WIDTH     (WIDTH),
        .RESET_VAL (NOP_INSTR)
    ) u_hold_buffer (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .capture_i (STALL && !BRANCH_TAKEN),
        .release_i (BRANCH_TAKEN || !STALL),
        .din_i     (ROM_INSTR),
        .dout_o    (buf_instr)
    );

    assign ROM_ADDRESS = pc_q;
    assign IF_INSTR    = f2_valid_q ? buf_instr : NOP_INSTR;
    assign IF_PC       = f2_pc_q;
    assign IF_PC_PLUS4 = f2_pc_q + WIDTH'(PC_STEP);
    assign IF_VALID    = f2_valid_q;

endmodule : fetch_unit
